// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
//   Shared types and defaults for the successive-approximation ADC controller
//   and its synchroniser.
//   Contents:
//     sar_state_t         FSM state encoding of the SAR controller
//     SAR_WIDTH           default result / DAC code width
//     SAR_SETTLE_DEFAULT  default DAC+comparator settling cycles per bit
//     SAR_SYNC_DEFAULT    default comparator synchroniser depth
//     ctr_width()         counter width able to hold 0..n-1, never less than 1
// -----------------------------------------------------------------------------
package sar_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SET_BIT,
      SETTLE,
      SAMPLE,
      DONE
   } sar_state_t;

   localparam int SAR_WIDTH          = 8;
   localparam int SAR_SETTLE_DEFAULT = 16;
   localparam int SAR_SYNC_DEFAULT   = 2;

   // $clog2(1) is 0, which would give a zero-width counter.
   function automatic int ctr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : sar_pkg

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
//   Generic multi-flop synchroniser for a single asynchronous input bit.
//   Shared by the SAR and ramp conversion paths.
//   Parameters:
//     STAGES  number of flops in the chain (>= 2)
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous active-high reset, clears the chain
//     d_i    in   asynchronous input
//     q_o    out  input re-timed to clk after STAGES edges
// -----------------------------------------------------------------------------
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   if (STAGES < 2) begin : g_bad_stages
      $error("sync_ff: STAGES must be at least 2");
   end

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule : sync_ff

// File: rtl/sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// sar_adc_ctrl
//   Successive-approximation controller for the discrete ADC front end.
//   Drives a trial code onto the R2R DAC one bit at a time (MSB first), waits
//   for the DAC and comparator to settle, samples the synchronised comparator
//   and keeps or clears the trial bit. A finished conversion is committed to
//   sar_approx_data together with a one-cycle sar_done strobe.
//   Reset release is expected to be synchronous to clk (done upstream).
//   Parameters:
//     WIDTH          result / DAC code width in bits
//     SETTLE_CYCLES  settling cycles per bit, >= SYNC_STAGES+1
//     SYNC_STAGES    comparator synchroniser depth, >= 2
//   Ports:
//     clk                 in   system clock
//     reset               in   asynchronous active-high reset
//     enable              in   high = convert continuously, low = idle / abort
//     comparator_out_raw  in   asynchronous comparator, 1 = Vin >= V(R2R_out)
//     R2R_out             out  trial code to the R2R DAC
//     sar_approx_data     out  last completed conversion result
//     sar_done            out  one-cycle pulse when sar_approx_data updates
//     busy                out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module sar_adc_ctrl
   import sar_pkg::*;
#(
   parameter int WIDTH         = SAR_WIDTH,
   parameter int SETTLE_CYCLES = SAR_SETTLE_DEFAULT,
   parameter int SYNC_STAGES   = SAR_SYNC_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             comparator_out_raw,
   output logic [WIDTH-1:0] R2R_out,
   output logic [WIDTH-1:0] sar_approx_data,
   output logic             sar_done,
   output logic             busy
);

   // The comparator must have propagated through the synchroniser before the
   // SAMPLE state reads it, otherwise a bit decision uses the previous trial.
   if (SETTLE_CYCLES < SYNC_STAGES + 1) begin : g_bad_settle
      $error("sar_adc_ctrl: SETTLE_CYCLES must be >= SYNC_STAGES+1");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("sar_adc_ctrl: WIDTH must be at least 1");
   end

   localparam int CNT_W = ctr_width(SETTLE_CYCLES);
   localparam int IDX_W = ctr_width(WIDTH);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

   // ---------------------------------------------------------------------------
   // Comparator synchroniser
   // ---------------------------------------------------------------------------
   logic comp_sync;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_comp_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (comparator_out_raw),
      .q_o   (comp_sync)
   );

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   sar_state_t       state_q,      state_d;
   logic [WIDTH-1:0] result_q,     result_d;
   logic [WIDTH-1:0] r2r_q,        r2r_d;
   logic [WIDTH-1:0] data_q,       data_d;
   logic             done_q,       done_d;
   logic [IDX_W-1:0] bit_idx_q,    bit_idx_d;
   logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;

   // Result with the current bit decided from the comparator.
   logic [WIDTH-1:0] result_sampled;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         result_q     <= '0;
         r2r_q        <= '0;
         data_q       <= '0;
         done_q       <= 1'b0;
         bit_idx_q    <= '0;
         settle_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         result_q     <= result_d;
         r2r_q        <= r2r_d;
         data_q       <= data_d;
         done_q       <= done_d;
         bit_idx_q    <= bit_idx_d;
         settle_cnt_q <= settle_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves a
      // value unassigned, which would otherwise infer a latch.
      state_d        = state_q;
      result_d       = result_q;
      r2r_d          = r2r_q;
      data_d         = data_q;
      done_d         = 1'b0;
      bit_idx_d      = bit_idx_q;
      settle_cnt_d   = settle_cnt_q;
      result_sampled = result_q;

      unique case (state_q)
         IDLE: begin
            if (enable) begin
               result_d  = '0;
               bit_idx_d = MSB_IDX;
               state_d   = SET_BIT;
            end
         end

         SET_BIT: begin
            r2r_d        = result_q | (ONE << bit_idx_q);
            settle_cnt_d = SETTLE_LOAD;
            state_d      = SETTLE;
         end

         SETTLE: begin
            if (settle_cnt_q == '0) begin
               state_d = SAMPLE;
            end else begin
               settle_cnt_d = settle_cnt_q - 1'b1;
            end
         end

         SAMPLE: begin
            result_sampled[bit_idx_q] = comp_sync;
            result_d                  = result_sampled;
            if (bit_idx_q == '0) begin
               // Present the final code on the DAC while the result commits.
               r2r_d   = result_sampled;
               state_d = DONE;
            end else begin
               bit_idx_d = bit_idx_q - 1'b1;
               state_d   = SET_BIT;
            end
         end

         DONE: begin
            // Commits even if enable dropped during this cycle.
            data_d  = result_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort: leave the DAC at zero and never publish a partial result.
      if (!enable && (state_q inside {SET_BIT, SETTLE, SAMPLE})) begin
         state_d = IDLE;
         r2r_d   = '0;
      end
   end

   assign R2R_out         = r2r_q;
   assign sar_approx_data = data_q;
   assign sar_done        = done_q;
   assign busy            = (state_q != IDLE);

endmodule : sar_adc_ctrl
